as_dbus_arb: RTL

Two-master, one-slave data-bus arbiter placed between the core load/store port (master 0), the JTAG debug memory-access port (master 1) and the shared data-memory/GPIO slave of `as_top_mem`. It grants one transaction at a time with round-robin fairness, holds the granted request stable on the slave port until the slave completes it, and returns a single-cycle response to the owner. A wait-state timeout aborts stuck accesses with an error response.

---
 rtl/as_dbus_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/as_dbus_arb.sv
// Two-master, one-slave data-bus arbiter with round-robin grant, latched slave
// request, single-cycle response and wait-state timeout abort.
module as_dbus_arb #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ready_i,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  localparam int              BE_W     = DATA_W / 8;
  localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                prio_r;
  logic                owner_r;
  logic [7:0]          cnt_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                grant_s;
  logic                win_s;
  logic                done_s;
  logic                abort_s;
  logic                sel_we_s;
  logic [BE_W-1:0]     sel_be_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  assign sel_we_s    = win_s ? m1_we_i    : m0_we_i;
  assign sel_be_s    = win_s ? m1_be_i    : m0_be_i;
  assign sel_addr_s  = win_s ? m1_addr_i  : m0_addr_i;
  assign sel_wdata_s = win_s ? m1_wdata_i : m0_wdata_i;
  assign m0_rdata_o  = rdata_r;
  assign m1_rdata_o  = rdata_r;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration, grant strobes and next-state decode
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    win_s       = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          grant_s = 1'b1;
          win_s   = prio_r;
        end else if (m0_req_i) begin
          grant_s = 1'b1;
          win_s   = 1'b0;
        end else if (m1_req_i) begin
          grant_s = 1'b1;
          win_s   = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        if (grant_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // ready wins over a coincident timeout expiry
        if (s_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // grants are held off while reset is asserted so outputs read zero
    m0_gnt_o = rst_i & grant_s & ~win_s;
    m1_gnt_o = rst_i & grant_s & win_s;
  end

  // Latched slave request, owner/priority tracking and response pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prio_r      <= 1'b0;
      owner_r     <= 1'b0;
      cnt_r       <= 8'd0;
      rdata_r     <= '0;
      s_req_o     <= 1'b0;
      s_we_o      <= 1'b0;
      s_be_o      <= '0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
    end else begin
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      if (grant_s) begin
        owner_r   <= win_s;
        prio_r    <= ~win_s;
        cnt_r     <= 8'd0;
        s_req_o   <= 1'b1;
        s_we_o    <= sel_we_s;
        s_be_o    <= sel_be_s;
        s_addr_o  <= sel_addr_s;
        s_wdata_o <= sel_wdata_s;
      end else if (done_s || abort_s) begin
        s_req_o     <= 1'b0;
        m0_rvalid_o <= ~owner_r;
        m1_rvalid_o <= owner_r;
        m0_err_o    <= abort_s & ~owner_r;
        m1_err_o    <= abort_s & owner_r;
        if (abort_s || s_we_o) begin
          rdata_r <= '0;
        end else begin
          rdata_r <= s_rdata_i;
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
